// File: rtl/ring_shift_pkg.sv
// Shared encodings for the ring shift register: mode opcodes and FSM state type.
package ring_shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_ROL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_SHL  = 3'b100;
  localparam logic [2:0] MODE_SHR  = 3'b101;
  localparam logic [2:0] MODE_JSL  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {IDLE, ROT} state_t;

endpackage

// File: rtl/ring_step.sv
// One-step next value of the register; load, hold and reserved pass q through.
module ring_step
  import ring_shift_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             sin,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = q;
    case (op)
      MODE_ROL: nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR: nxt = {q[0], q[WIDTH-1:1]};
      MODE_SHL: nxt = {q[WIDTH-2:0], sin};
      MODE_SHR: nxt = {sin, q[WIDTH-1:1]};
      MODE_JSL: nxt = {q[WIDTH-2:0], ~q[WIDTH-1]};
      default:  nxt = q;
    endcase
  end

endmodule

// File: rtl/ring_shift_reg_param.sv
// Parameterized ring/shift register with single-step modes and a counted
// multi-step rotate that runs autonomously for amt edges.
module ring_shift_reg_param
  import ring_shift_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             sin,
  input  logic             start,
  input  logic             dir,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic             dir_r, dir_n;
  logic [WIDTH-1:0] q_n, step_q;
  logic [2:0]       op_sel;
  logic             busy_n, done_n;

  // ROT reuses the same step logic with the latched direction as opcode
  assign op_sel = (state == ROT) ? (dir_r ? MODE_ROR : MODE_ROL) : mode;

  ring_step #(.WIDTH(WIDTH)) u_step (
    .q   (q),
    .op  (op_sel),
    .sin (sin),
    .nxt (step_q)
  );

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dir_r <= 1'b0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dir_r <= dir_n;
      q     <= q_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dir_n   = dir_r;
    q_n     = q;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (amt != '0) begin
            state_n = ROT;
            cnt_n   = amt;
            dir_n   = dir;
            busy_n  = 1'b1;
          end else begin
            done_n  = 1'b1;
          end
        end else if (en) begin
          q_n = (mode == MODE_LOAD) ? data : step_q;
        end
      end
      ROT: begin
        q_n   = step_q;
        cnt_n = cnt - 1'b1;
        if (cnt == {{(AMT_W-1){1'b0}}, 1'b1}) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
